mem_port_arbiter: RTL and testbench

Two-requester arbiter that lets the fetch stage and the memory stage of the five-stage pipeline share one single-port unified memory. It sequences each access through a small FSM, applies data-over-fetch priority with a bounded starvation guard, and enforces a timeout on a variable-latency memory. It produces the global freeze signal the pipeline registers need while an access is outstanding.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
//   arb_state_t        : arbiter FSM state encoding
//   NOP_INSTR          : instruction returned to fetch when an access times out
//   DEF_MAX_DATA_BURST : default cap on data grants that bypass a waiting fetch
//   DEF_TIMEOUT        : default grant-state cycle budget before abort
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned DEF_MAX_DATA_BURST = 4;
  localparam int unsigned DEF_TIMEOUT        = 255;
  localparam int unsigned TMO_W              = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port unified memory between the fetch and memory stages.
// Data has priority over fetch unless MAX_DATA_BURST data grants in a row
// have bypassed a waiting fetch. Each access runs IDLE -> GRANT -> DONE and is
// aborted after TIMEOUT grant cycles without an ack.
// Ports:
//   i_clk, i_reset                     clock, async active-high reset
//   i_if_req/i_if_addr                 fetch read request
//   o_if_rdata/o_if_valid              fetch completion (one-cycle pulse)
//   i_d_req/i_d_we/i_d_addr/i_d_wdata  data request
//   o_d_rdata/o_d_valid                data completion (one-cycle pulse)
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata, i_mem_ack/i_mem_rdata
//                                      memory side
//   o_stall                            pipeline freeze (combinational)
//   o_timeout                          marks the completion of an aborted access
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = DEF_MAX_DATA_BURST,
  parameter int unsigned TIMEOUT        = DEF_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_valid,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic [31:0] o_d_rdata,
  output logic        o_d_valid,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall,
  output logic        o_timeout
);

  localparam int unsigned        BURST_W   = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);

  arb_state_t         state;
  arb_state_t         next_state;
  logic [BURST_W-1:0] burst_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               gnt_d;
  logic               in_grant;
  logic               tmo_hit;
  logic               enter_i;
  logic               enter_d;
  logic               enter_done;
  logic               aborting;

  assign in_grant = (state == GRANT_I) || (state == GRANT_D);
  assign tmo_hit  = in_grant && (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_d_req && ((burst_cnt < BURST_MAX) || !i_if_req)) next_state = GRANT_D;
        else if (i_if_req)                                     next_state = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (i_mem_ack || tmo_hit) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Transition decodes feeding the output registers; ack beats a same-cycle timeout
  always_comb begin
    enter_i    = 1'b0;
    enter_d    = 1'b0;
    enter_done = 1'b0;
    aborting   = 1'b0;
    if (state == IDLE) begin
      enter_i = (next_state == GRANT_I);
      enter_d = (next_state == GRANT_D);
    end
    if (in_grant && (next_state == DONE)) begin
      enter_done = 1'b1;
      aborting   = !i_mem_ack;
    end
  end

  // Starvation guard: counts data grants that bypassed a waiting fetch
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      burst_cnt <= '0;
    end else if (enter_d) begin
      if (!i_if_req)                    burst_cnt <= '0;
      else if (burst_cnt != BURST_MAX)  burst_cnt <= burst_cnt + 1'b1;
    end else if (enter_i) begin
      burst_cnt <= '0;
    end
  end

  // Grant-state cycle counter for the memory timeout
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                 tmo_cnt <= '0;
    else if (enter_i || enter_d) tmo_cnt <= '0;
    else if (in_grant)           tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Memory-side request, latched from the winning port on grant entry
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      gnt_d       <= 1'b0;
    end else if (enter_i) begin
      o_mem_req   <= 1'b1;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= i_if_addr;
      o_mem_wdata <= '0;
      gnt_d       <= 1'b0;
    end else if (enter_d) begin
      o_mem_req   <= 1'b1;
      o_mem_we    <= i_d_we;
      o_mem_addr  <= i_d_addr;
      o_mem_wdata <= i_d_wdata;
      gnt_d       <= 1'b1;
    end else if (enter_done) begin
      o_mem_req   <= 1'b0;
    end
  end

  // Completion pulses and returned data, presented during DONE
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_if_valid <= 1'b0;
      o_d_valid  <= 1'b0;
      o_timeout  <= 1'b0;
      o_if_rdata <= '0;
      o_d_rdata  <= '0;
    end else begin
      o_if_valid <= enter_done && !gnt_d;
      o_d_valid  <= enter_done && gnt_d;
      o_timeout  <= aborting;
      if (enter_done && !gnt_d) o_if_rdata <= aborting ? NOP_INSTR : i_mem_rdata;
      if (enter_done && gnt_d)  o_d_rdata  <= (aborting || o_mem_we) ? '0 : i_mem_rdata;
    end
  end

  // Freeze while a request is outstanding and not completing this cycle
  assign o_stall = (i_if_req & ~o_if_valid) | (i_d_req & ~o_d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model with directed
// scenarios followed by randomized request/latency traffic.
module tb_mem_port_arbiter;

  localparam int MAXB = 4;
  localparam int TMO  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_valid;
  logic        i_d_req;
  logic        i_d_we;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [31:0] o_d_rdata;
  logic        o_d_valid;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_stall;
  logic        o_timeout;

  mem_port_arbiter #(.MAX_DATA_BURST(MAXB), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_rdata(o_if_rdata), .o_if_valid(o_if_valid),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_rdata(o_d_rdata), .o_d_valid(o_d_valid),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_stall(o_stall), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic [31:0] if_q[$];
  dreq_t       d_q[$];
  bit          gnt_log[$];

  int checks = 0;
  int errors = 0;

  // Model: one access at a time, described by its cycle window and outcome
  int          k, busy_until, g_start, g_end, done_cyc, ack_cyc, streak;
  bit          g_port_d, g_we, exp_tmo;
  logic [31:0] g_addr, g_wdata, exp_rdata, ack_data;
  bit          if_drop, d_drop, rnd_mode, stray_en, force_data_en, prev_mreq;
  int          force_lat, req_hi_cnt;
  logic [31:0] force_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; busy_until = -1; g_start = 1; g_end = 0; done_cyc = -1; ack_cyc = -1;
    streak = 0; if_drop = 0; d_drop = 0; prev_mreq = 0;
    if_q.delete(); d_q.delete();
  endtask

  task automatic push_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    dreq_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    d_q.push_back(r);
  endtask

  function automatic logic [31:0] pack_log(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], (i < gnt_log.size()) ? gnt_log[i] : 1'b0};
    return v;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, advance the model
  task automatic cycle();
    bit    exp_mreq, exp_ifv, exp_dv, pick_d, stray;
    int    lat;
    dreq_t r;
    if (if_drop) begin i_if_req = 1'b0; if_drop = 1'b0; end
    if (d_drop)  begin i_d_req  = 1'b0; d_drop  = 1'b0; end

    exp_mreq = (k >= g_start) && (k <= g_end);
    exp_ifv  = (k == done_cyc) && !g_port_d;
    exp_dv   = (k == done_cyc) && g_port_d;
    chk("mem_req",  32'(o_mem_req),  32'(exp_mreq));
    chk("if_valid", 32'(o_if_valid), 32'(exp_ifv));
    chk("d_valid",  32'(o_d_valid),  32'(exp_dv));
    chk("timeout",  32'(o_timeout),  32'((k == done_cyc) && exp_tmo));
    if (exp_mreq) begin
      chk("mem_addr", o_mem_addr, g_addr);
      chk("mem_we", 32'(o_mem_we), 32'(g_we));
      if (g_we) chk("mem_wdata", o_mem_wdata, g_wdata);
    end
    if (exp_ifv) chk("if_rdata", o_if_rdata, exp_rdata);
    if (exp_dv)  chk("d_rdata", o_d_rdata, exp_rdata);
    if (o_mem_req) req_hi_cnt++;
    if (o_mem_req && !prev_mreq) gnt_log.push_back(i_d_req && (o_mem_addr == i_d_addr));
    prev_mreq = o_mem_req;
    if (exp_ifv) if_drop = 1'b1;
    if (exp_dv)  d_drop  = 1'b1;

    if (rnd_mode) begin
      if (if_q.size() == 0 && $urandom_range(0, 2) == 0) if_q.push_back($urandom() & 32'hFFFF_FFFC);
      if (d_q.size() == 0 && $urandom_range(0, 2) == 0)
        push_d(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom());
    end
    if (!i_if_req && if_q.size() != 0) begin i_if_addr = if_q.pop_front(); i_if_req = 1'b1; end
    if (!i_d_req && d_q.size() != 0) begin
      r = d_q.pop_front();
      i_d_we = r.we; i_d_addr = r.addr; i_d_wdata = r.wdata; i_d_req = 1'b1;
    end

    // Acks outside a grant window are stray and must be ignored
    stray = rnd_mode ? ($urandom_range(0, 3) == 0) : stray_en;
    i_mem_ack = 1'b0;
    i_mem_rdata = $urandom();
    if (k == ack_cyc) begin i_mem_ack = 1'b1; i_mem_rdata = ack_data; end
    else if (stray && k > g_end) i_mem_ack = 1'b1;

    if (k > busy_until && (i_if_req || i_d_req)) begin
      pick_d = i_d_req && ((streak < MAXB) || !i_if_req);
      if (pick_d) begin
        streak = i_if_req ? streak + 1 : 0;
        g_port_d = 1; g_we = i_d_we; g_addr = i_d_addr; g_wdata = i_d_wdata;
      end else begin
        streak = 0;
        g_port_d = 0; g_we = 0; g_addr = i_if_addr; g_wdata = '0;
      end
      lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, TMO + 2));
      g_start = k + 1;
      if (lat <= TMO) begin
        ack_cyc   = k + lat;
        g_end     = ack_cyc;
        exp_tmo   = 0;
        ack_data  = force_data_en ? force_data : $urandom();
        exp_rdata = (g_port_d && g_we) ? 32'h0 : ack_data;
      end else begin
        ack_cyc   = -1;
        g_end     = k + TMO;
        exp_tmo   = 1;
        exp_rdata = g_port_d ? 32'h0 : NOP;
      end
      done_cyc   = g_end + 1;
      busy_until = done_cyc;
    end

    #1;
    chk("stall", 32'(o_stall), 32'((i_if_req && !exp_ifv) || (i_d_req && !exp_dv)));
    @(posedge i_clk);
    #1;
    k++;
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    while (!(k > busy_until && !i_if_req && !i_d_req && if_q.size() == 0 && d_q.size() == 0)
           && n < bound) begin
      cycle();
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $error("FAIL idle_wait observed=busy expected=idle within %0d cycles", bound);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_if_req = 0; i_if_addr = '0; i_d_req = 0; i_d_we = 0;
    i_d_addr = '0; i_d_wdata = '0; i_mem_ack = 0; i_mem_rdata = '0;
    rnd_mode = 0; stray_en = 0; force_lat = 0; force_data_en = 0; force_data = '0;
    req_hi_cnt = 0; exp_tmo = 0; g_port_d = 0; g_we = 0;
    g_addr = '0; g_wdata = '0; exp_rdata = '0; ack_data = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_mem_req", 32'(o_mem_req), 32'h0);
    chk("rst_if_valid", 32'(o_if_valid), 32'h0);
    chk("rst_d_valid", 32'(o_d_valid), 32'h0);
    chk("rst_timeout", 32'(o_timeout), 32'h0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_if_rdata", o_if_rdata, 32'h0);
    chk("rst_d_rdata", o_d_rdata, 32'h0);
    chk("rst_stall", 32'(o_stall), 32'h0);
    i_reset = 1'b0;

    // Fetch read, ack one cycle after the request
    force_lat = 1; force_data_en = 1; force_data = 32'h0050_0093;
    if_q.push_back(32'h40);
    run_until_idle(20);
    chk("t1_if_rdata", o_if_rdata, 32'h0050_0093);
    force_data_en = 0;

    // Simultaneous fetch and data read: data first
    force_lat = 2; gnt_log.delete();
    push_d(1'b0, 32'h100, 32'h0);
    if_q.push_back(32'h44);
    run_until_idle(30);
    chk("t2_grants", 32'(gnt_log.size()), 32'd2);
    chk("t2_order", pack_log(2), 32'b10);

    // Back-to-back data with fetch pending: guard lets fetch in after MAXB
    force_lat = 1; gnt_log.delete();
    for (int i = 0; i < 6; i++) push_d(1'(i % 2), 32'h300 + 32'(4 * i), $urandom());
    if_q.push_back(32'h80);
    if_q.push_back(32'h84);
    run_until_idle(100);
    chk("t3_order", pack_log(6), 32'b111101);

    // Data write, memory never acks; stray acks afterwards
    force_lat = TMO + 1; stray_en = 1; req_hi_cnt = 0;
    push_d(1'b1, 32'h200, 32'hDEAD_BEEF);
    run_until_idle(30);
    repeat (3) cycle();
    stray_en = 0;
    chk("t4_req_cycles", 32'(req_hi_cnt), 32'(TMO));

    // Fetch timeout returns NOP
    if_q.push_back(32'h48);
    run_until_idle(30);
    chk("t5_nop", o_if_rdata, NOP);

    // Reset in the middle of a data grant with fetch waiting
    force_lat = 50;
    push_d(1'b0, 32'h400, 32'h0);
    if_q.push_back(32'h4C);
    repeat (3) cycle();
    chk("t6_req_before", 32'(o_mem_req), 32'h1);
    #2 i_reset = 1'b1;
    #1;
    chk("t6_req_async", 32'(o_mem_req), 32'h0);
    @(posedge i_clk);
    #1;
    chk("t6_no_d_valid", 32'(o_d_valid), 32'h0);
    chk("t6_no_if_valid", 32'(o_if_valid), 32'h0);
    chk("t6_no_timeout", 32'(o_timeout), 32'h0);
    i_if_req = 0; i_d_req = 0; i_mem_ack = 0;
    model_reset();
    i_reset = 1'b0;
    force_lat = 3; gnt_log.delete();
    for (int i = 0; i < 4; i++) push_d(1'b0, 32'h500 + 32'(4 * i), 32'h0);
    if_q.push_back(32'h90);
    run_until_idle(100);
    chk("t6_order", pack_log(5), 32'b11110);

    // Randomized traffic
    force_lat = 0; rnd_mode = 1;
    repeat (1500) cycle();
    rnd_mode = 0;
    run_until_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
